hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_pkg.sv | 19 +
 rtl/hazard_control_unit_load_use_detect.sv | 21 ++
 rtl/hazard_control_unit.sv | 131 +++++++++++++
 tb/tb_hazard_control_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard control slice.
//   hcu_state_e        : memory-wait supervisor states (RUN, WAIT, FAULT)
//   WAIT_LIMIT_DEFAULT : default number of WAIT cycles before a memory timeout
//   FWD_*              : 2-bit forwarding mux selects consumed by the EX stage
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } hcu_state_e;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Combinational load-use hazard detector.
//   rs1, rs2           : source registers of the instruction in ID
//   uses_rs1, uses_rs2 : ID instruction actually reads that source
//   rd                 : destination register in ID/EX
//   mem_read           : instruction in EX is a load
//   load_use           : ID needs a value the EX load has not produced yet
module load_use_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] rd,
  input  logic       mem_read,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read && (rd != 5'd0) &&
                    ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and
// data-memory wait freezes with a timeout supervisor.
//   clk, arst_n          : clock, synchronous active-low reset
//   rs1_ID .. rd_ID_EX   : operand / destination info for load-use detection
//   mem_read_ID_EX       : EX instruction is a load
//   branch_taken_EX      : branch resolved taken in EX
//   mem_req_MEM          : MEM instruction accesses data memory
//   mem_ready            : data memory completes this cycle
//   pc_write, *_write    : PC and pipeline register enables
//   if_id_flush, id_ex_flush, mem_wb_bubble : NOP injection controls
//   mem_timeout          : sticky fault, high while in FAULT
//   stall_cycles         : saturating count of freeze / load-use stall cycles
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rd_ID_EX,
  input  logic             mem_read_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  hcu_state_e state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       load_use;
  logic       freeze;
  logic       stall_now;

  load_use_detect u_load_use_detect (
    .rs1      (rs1_ID),
    .rs2      (rs2_ID),
    .uses_rs1 (uses_rs1_ID),
    .uses_rs2 (uses_rs2_ID),
    .rd       (rd_ID_EX),
    .mem_read (mem_read_ID_EX),
    .load_use (load_use)
  );

  // Freeze follows mem_ready directly so a completing access releases the
  // pipeline in the same cycle; FAULT freezes unconditionally.
  assign freeze      = (state == ST_FAULT) || (mem_req_MEM && !mem_ready);
  assign stall_now   = freeze || (load_use && !branch_taken_EX);
  assign mem_timeout = (state == ST_FAULT);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_now && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      ST_RUN: begin
        if (mem_req_MEM && !mem_ready) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_FAULT: ;
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode, priority freeze > branch > load-use.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken_EX) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_hazard_control_unit;

  localparam int unsigned LIMIT = 255;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID_EX;
  logic        uses_rs1_ID, uses_rs2_ID, mem_read_ID_EX;
  logic        branch_taken_EX, mem_req_MEM, mem_ready;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
  logic [15:0] stall_cycles;
  logic [7:0]  obs;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write,
  //  if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout}
  assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout};

  hazard_control_unit #(.WAIT_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .uses_rs1_ID     (uses_rs1_ID),
    .uses_rs2_ID     (uses_rs2_ID),
    .rd_ID_EX        (rd_ID_EX),
    .mem_read_ID_EX  (mem_read_ID_EX),
    .branch_taken_EX (branch_taken_EX),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  task automatic idle_inputs();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_ID_EX = 5'd0;
    uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; mem_read_ID_EX = 1'b0;
    branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    rd_ID_EX = r; rs1_ID = r; uses_rs1_ID = 1'b1; mem_read_ID_EX = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    // reset lands while waiting on memory
    do_reset();
    #1;
    total++;
    if (obs !== 8'b1111_0000) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs, 8'b1111_0000);
    end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL reset_stall: got %0d want 0", stall_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    total++;
    if (obs !== 8'b0011_0100) begin
      bad++; $display("FAIL load_use_outputs: got %b want %b", obs, 8'b0011_0100);
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd1) begin
      bad++; $display("FAIL load_use_count: got %0d want 1", stall_cycles);
    end
    idle_inputs();
    #1;
    total++;
    if (obs !== 8'b1111_0000) begin
      bad++; $display("FAIL load_use_release: got %b want %b", obs, 8'b1111_0000);
    end
    @(negedge clk);
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use(5'd5);
    branch_taken_EX = 1'b1;
    #1;
    total++;
    if (obs !== 8'b1111_1100) begin
      bad++; $display("FAIL branch_over_load_use: got %b want %b", obs, 8'b1111_1100);
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL branch_count: got %0d want 0", stall_cycles);
    end
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== 8'b0000_0010) begin
      bad++; $display("FAIL freeze_over_branch: got %b want %b", obs, 8'b0000_0010);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== 8'b1111_1100) begin
      bad++; $display("FAIL ready_release_branch: got %b want %b", obs, 8'b1111_1100);
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd1) begin
      bad++; $display("FAIL freeze_branch_count: got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== 8'b0000_0010) begin
        bad++; $display("FAIL mem_wait_freeze[%0d]: got %b want %b", i, obs, 8'b0000_0010);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== 8'b1111_0000) begin
      bad++; $display("FAIL mem_wait_release: got %b want %b", obs, 8'b1111_0000);
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd3) begin
      bad++; $display("FAIL mem_wait_count: got %0d want 3", stall_cycles);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    rd_ID_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
    uses_rs1_ID = 1'b1; uses_rs2_ID = 1'b1; mem_read_ID_EX = 1'b1;
    #1;
    total++;
    if (obs !== 8'b1111_0000) begin
      bad++; $display("FAIL rd_zero_outputs: got %b want %b", obs, 8'b1111_0000);
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL rd_zero_count: got %0d want 0", stall_cycles);
    end
  endtask

  // Reference model: tracks how many consecutive cycles an outstanding memory
  // access has gone unanswered; WAIT_LIMIT+1 unanswered cycles is a timeout.
  task automatic test_random();
    bit          m_fault;
    int unsigned m_pending;
    int unsigned m_stalls;
    bit          fr, lu, hit1, hit2;
    logic [7:0]  exp;
    logic [15:0] exp_cnt;
    do_reset();
    m_fault = 0; m_pending = 0; m_stalls = 0;
    for (int n = 0; n < 1500; n++) begin
      rs1_ID          = 5'($urandom_range(0, 3));
      rs2_ID          = 5'($urandom_range(0, 3));
      rd_ID_EX        = 5'($urandom_range(0, 3));
      uses_rs1_ID     = 1'($urandom_range(0, 1));
      uses_rs2_ID     = 1'($urandom_range(0, 1));
      mem_read_ID_EX  = 1'($urandom_range(0, 1));
      branch_taken_EX = ($urandom_range(0, 3) == 0);
      mem_req_MEM     = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 3) != 0);
      #1;
      hit1 = uses_rs1_ID && (rs1_ID == rd_ID_EX);
      hit2 = uses_rs2_ID && (rs2_ID == rd_ID_EX);
      lu   = mem_read_ID_EX && (rd_ID_EX != 0) && (hit1 || hit2);
      fr   = m_fault || (mem_req_MEM && !mem_ready);
      if (fr)                   exp = 8'b0000_0010;
      else if (branch_taken_EX) exp = 8'b1111_1100;
      else if (lu)              exp = 8'b0011_0100;
      else                      exp = 8'b1111_0000;
      exp[0] = m_fault;
      exp_cnt = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL random_outputs[%0d]: got %b want %b", n, obs, exp);
      end
      total++;
      if (stall_cycles !== exp_cnt) begin
        bad++; $display("FAIL random_count[%0d]: got %0d want %0d", n, stall_cycles, exp_cnt);
      end
      if (fr || (lu && !branch_taken_EX)) m_stalls++;
      if (!m_fault) begin
        if (m_pending == 0) begin
          if (mem_req_MEM && !mem_ready) m_pending = 1;
        end else if (mem_ready) begin
          m_pending = 0;
        end else begin
          m_pending++;
          if (m_pending == LIMIT + 1) m_fault = 1;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fault_and_saturation();
    int unsigned edges;
    do_reset();
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    edges = 0;
    while (mem_timeout !== 1'b1 && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    total++;
    if (edges != LIMIT + 1) begin
      bad++; $display("FAIL fault_latency: got %0d cycles want %0d", edges, LIMIT + 1);
    end
    total++;
    if (stall_cycles !== 16'(LIMIT + 1)) begin
      bad++; $display("FAIL fault_count: got %0d want %0d", stall_cycles, LIMIT + 1);
    end
    mem_req_MEM = 1'b0; mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== 8'b0000_0011) begin
      bad++; $display("FAIL fault_freeze: got %b want %b", obs, 8'b0000_0011);
    end
    repeat (65600) @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      bad++; $display("FAIL saturate: got %h want ffff", stall_cycles);
    end
    repeat (3) @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      bad++; $display("FAIL saturate_hold: got %h want ffff", stall_cycles);
    end
    do_reset();
    #1;
    total++;
    if (obs !== 8'b1111_0000) begin
      bad++; $display("FAIL fault_reset_outputs: got %b want %b", obs, 8'b1111_0000);
    end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL fault_reset_count: got %0d want 0", stall_cycles);
    end
  endtask

  initial begin
    arst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_rd_zero();
    test_random();
    test_fault_and_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
